// File: rtl/lsu_axi_rsp_pkg.sv
// ---------------------------------------------------------------------------
// lsu_axi_rsp_pkg
// Shared types and helpers for the LSU-side AXI responder.
//   axi_resp_e  : response codes carried on B and R
//   axi_burst_e : legal burst encodings (10/11 are illegal)
//   wr_state_e  : write channel FSM states
//   rd_state_e  : read channel FSM states
//   AXI_SIZE_8B : the only legal beat size encoding
//   burst_step  : word-address increment applied after every beat
// ---------------------------------------------------------------------------
package lsu_axi_rsp_pkg;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic [1:0] {
        AXI_FIXED = 2'b00,
        AXI_INCR  = 2'b01
    } axi_burst_e;

    typedef enum logic [1:0] {
        WIDLE = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RIDLE = 2'd0,
        RRD   = 2'd1,
        RDATA = 2'd2
    } rd_state_e;

    localparam logic [2:0] AXI_SIZE_8B = 3'd3;

    // Width of the step returned by burst_step; callers keep the low
    // ADDR_W bits so the address wraps naturally.
    localparam int STEP_W = 16;

    // FIXED holds the address; every other encoding (including the illegal
    // ones, which are only flagged when error checking is built) steps by
    // 1 << str words.
    function automatic logic [STEP_W-1:0] burst_step(input logic [1:0] burst,
                                                     input logic [2:0] str);
        if (burst == AXI_FIXED) begin
            return '0;
        end
        return STEP_W'(1) << str;
    endfunction

endpackage

// File: rtl/lsu_axi_rsp_if.sv
// ---------------------------------------------------------------------------
// lsu_axi_rsp_if
// Bundle of the LSU <-> responder AXI-style channels (AW, W, B, AR, R).
//   master : LSU side, drives requests, write data and response readies
//   slave  : responder side, drives readies and responses
// Parameters: DATA_W (beat width), ADDR_W (word-address width).
// ---------------------------------------------------------------------------
interface lsu_axi_rsp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    // AW
    logic [7:0]          lsu_axi_awid;
    logic [ADDR_W-1:0]   lsu_axi_awaddr;
    logic [7:0]          lsu_axi_awlen;
    logic [2:0]          lsu_axi_awsize;
    logic [1:0]          lsu_axi_awburst;
    logic [2:0]          lsu_axi_awstr;
    logic                lsu_axi_awvld;
    logic                axi_lsu_awrdy;
    logic [11:0]         lsu_axi_oram_addr;
    // W
    logic [DATA_W-1:0]   lsu_axi_wdata;
    logic [DATA_W/8-1:0] lsu_axi_wstrb;
    logic                lsu_axi_wlast;
    logic                lsu_axi_wvld;
    logic                axi_lsu_wrdy;
    // B
    logic                axi_lsu_bid;
    logic [1:0]          axi_lsu_bresp;
    logic                axi_lsu_bvld;
    logic                lsu_axi_brdy;
    logic [11:0]         axi_lsu_resp_oram_addr;
    // AR
    logic [7:0]          lsu_axi_arid;
    logic [ADDR_W-1:0]   lsu_axi_araddr;
    logic [7:0]          lsu_axi_arlen;
    logic [2:0]          lsu_axi_arsize;
    logic [1:0]          lsu_axi_arburst;
    logic [2:0]          lsu_axi_arstr;
    logic                lsu_axi_arvld;
    logic                axi_lsu_arrdy;
    // R
    logic [7:0]          axi_lsu_rid;
    logic [DATA_W-1:0]   axi_lsu_rdata;
    logic [1:0]          axi_lsu_rresp;
    logic                axi_lsu_rlast;
    logic                axi_lsu_rvld;
    logic                lsu_axi_rrdy;

    modport master (
        output lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize,
               lsu_axi_awburst, lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr,
               lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast, lsu_axi_wvld,
               lsu_axi_brdy,
               lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
               lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arvld,
               lsu_axi_rrdy,
        input  axi_lsu_awrdy, axi_lsu_wrdy,
               axi_lsu_bid, axi_lsu_bresp, axi_lsu_bvld, axi_lsu_resp_oram_addr,
               axi_lsu_arrdy,
               axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
    );

    modport slave (
        input  lsu_axi_awid, lsu_axi_awaddr, lsu_axi_awlen, lsu_axi_awsize,
               lsu_axi_awburst, lsu_axi_awstr, lsu_axi_awvld, lsu_axi_oram_addr,
               lsu_axi_wdata, lsu_axi_wstrb, lsu_axi_wlast, lsu_axi_wvld,
               lsu_axi_brdy,
               lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
               lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arvld,
               lsu_axi_rrdy,
        output axi_lsu_awrdy, axi_lsu_wrdy,
               axi_lsu_bid, axi_lsu_bresp, axi_lsu_bvld, axi_lsu_resp_oram_addr,
               axi_lsu_arrdy,
               axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp, axi_lsu_rlast, axi_lsu_rvld
    );

endinterface

// File: rtl/lsu_axi_rsp_mem.sv
// ---------------------------------------------------------------------------
// lsu_axi_rsp_mem
// Simple dual-port data memory: one byte-strobed write port, one read port
// with a registered output. A read and a write to the same word in the same
// cycle returns the old contents. Contents are never reset.
// Ports:
//   clk      : clock
//   we_i     : write enable (qualified further per byte by wstrb_i)
//   waddr_i  : write word address
//   wdata_i  : write data
//   wstrb_i  : byte strobes
//   re_i     : read enable; rdata_o updates only when set
//   raddr_i  : read word address
//   rdata_o  : registered read data
// ---------------------------------------------------------------------------
module lsu_axi_rsp_mem #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;

    // One independent byte-wide array per lane keeps the strobed write a
    // plain per-lane write enable, which maps directly onto block RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_q [MEM_DEPTH];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (we_i && wstrb_i[gi]) begin
                    lane_q[waddr_i] <= wdata_i[gi*8 +: 8];
                end
                if (re_i) begin
                    rd_q <= lane_q[raddr_i];
                end
            end

            assign rdata_o[gi*8 +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/lsu_axi_rsp.sv
// ---------------------------------------------------------------------------
// lsu_axi_rsp
// AXI-style responder terminating the LSU DRAM master port. Independent
// write (WIDLE->WDATA->WRESP) and read (RIDLE->RRD->RDATA) FSMs share one
// dual-port word memory.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   axi    : lsu_axi_rsp_if.slave (AW/W/B/AR/R channels)
// Parameters: DATA_W, ADDR_W, MEM_DEPTH (must equal 2**ADDR_W).
// Build option: define LSU_AXI_RSP_ERR_CHK_EN to enable size/burst/beat-count
// checking with SLVERR responses; otherwise responses are always OKAY.
// ---------------------------------------------------------------------------
module lsu_axi_rsp
    import lsu_axi_rsp_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_axi_rsp_if.slave  axi
);

    // Holds readies low while in reset and lets them rise on the first edge
    // after release.
    logic live_q;

    // ---------------- write channel state ----------------
    wr_state_e          wr_state_q, wr_state_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [7:0]         wlen_q, wlen_d;
    logic [1:0]         wburst_q, wburst_d;
    logic [2:0]         wstr_q, wstr_d;
    logic               bid_q, bid_d;
    logic [11:0]        oram_q, oram_d;
    logic [8:0]         wbeat_q, wbeat_d;   // saturating count of accepted beats

    // ---------------- read channel state ----------------
    rd_state_e          rd_state_q, rd_state_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [7:0]         rlen_q, rlen_d;
    logic [1:0]         rburst_q, rburst_d;
    logic [2:0]         rstr_q, rstr_d;
    logic [7:0]         rid_q, rid_d;
    logic [7:0]         rbeat_q, rbeat_d;

    // ---------------- combinational outputs / memory controls ----------------
    logic               awrdy, wrdy, bvld, arrdy, rvld, rlast;
    logic               mem_we, mem_re;
    logic [DATA_W-1:0]  mem_rdata;
    logic [STEP_W-1:0]  wstep, rstep;
    logic               wr_err, rd_err;
    axi_resp_e          bresp, rresp;

    assign wstep = burst_step(wburst_q, wstr_q);
    assign rstep = burst_step(rburst_q, rstr_q);

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q     <= 1'b0;
            wr_state_q <= WIDLE;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wburst_q   <= '0;
            wstr_q     <= '0;
            bid_q      <= 1'b0;
            oram_q     <= '0;
            wbeat_q    <= '0;
            rd_state_q <= RIDLE;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rburst_q   <= '0;
            rstr_q     <= '0;
            rid_q      <= '0;
            rbeat_q    <= '0;
        end else begin
            live_q     <= 1'b1;
            wr_state_q <= wr_state_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wburst_q   <= wburst_d;
            wstr_q     <= wstr_d;
            bid_q      <= bid_d;
            oram_q     <= oram_d;
            wbeat_q    <= wbeat_d;
            rd_state_q <= rd_state_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rburst_q   <= rburst_d;
            rstr_q     <= rstr_d;
            rid_q      <= rid_d;
            rbeat_q    <= rbeat_d;
        end
    end

    // ---------------- write FSM ----------------
    always_comb begin
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wstr_d     = wstr_q;
        bid_d      = bid_q;
        oram_d     = oram_q;
        wbeat_d    = wbeat_q;
        awrdy      = 1'b0;
        wrdy       = 1'b0;
        bvld       = 1'b0;
        mem_we     = 1'b0;

        case (wr_state_q)
            WIDLE: begin
                awrdy = live_q;
                if (live_q && axi.lsu_axi_awvld) begin
                    waddr_d    = axi.lsu_axi_awaddr;
                    wlen_d     = axi.lsu_axi_awlen;
                    wburst_d   = axi.lsu_axi_awburst;
                    wstr_d     = axi.lsu_axi_awstr;
                    bid_d      = axi.lsu_axi_awid[0];
                    oram_d     = axi.lsu_axi_oram_addr;
                    wbeat_d    = '0;
                    wr_state_d = WDATA;
                end
            end
            WDATA: begin
                wrdy = 1'b1;
                if (axi.lsu_axi_wvld) begin
                    // Beats past len+1 are swallowed without touching memory.
                    mem_we  = (wbeat_q <= {1'b0, wlen_q}) && !wr_err;
                    waddr_d = waddr_q + wstep[ADDR_W-1:0];
                    if (wbeat_q != '1) begin
                        wbeat_d = wbeat_q + 9'd1;
                    end
                    if (axi.lsu_axi_wlast) begin
                        wr_state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                bvld = 1'b1;
                if (axi.lsu_axi_brdy) begin
                    wr_state_d = WIDLE;
                end
            end
            default: begin
                wr_state_d = WIDLE;
            end
        endcase
    end

    // ---------------- read FSM ----------------
    always_comb begin
        rd_state_d = rd_state_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rburst_d   = rburst_q;
        rstr_d     = rstr_q;
        rid_d      = rid_q;
        rbeat_d    = rbeat_q;
        arrdy      = 1'b0;
        rvld       = 1'b0;
        mem_re     = 1'b0;

        case (rd_state_q)
            RIDLE: begin
                arrdy = live_q;
                if (live_q && axi.lsu_axi_arvld) begin
                    raddr_d    = axi.lsu_axi_araddr;
                    rlen_d     = axi.lsu_axi_arlen;
                    rburst_d   = axi.lsu_axi_arburst;
                    rstr_d     = axi.lsu_axi_arstr;
                    rid_d      = axi.lsu_axi_arid;
                    rbeat_d    = '0;
                    rd_state_d = RRD;
                end
            end
            RRD: begin
                // Read issued here; the memory output register holds the
                // beat steady for as long as RDATA waits on rrdy.
                mem_re     = 1'b1;
                rd_state_d = RDATA;
            end
            RDATA: begin
                rvld = 1'b1;
                if (axi.lsu_axi_rrdy) begin
                    if (rbeat_q == rlen_q) begin
                        rd_state_d = RIDLE;
                    end else begin
                        raddr_d    = raddr_q + rstep[ADDR_W-1:0];
                        rbeat_d    = rbeat_q + 8'd1;
                        rd_state_d = RRD;
                    end
                end
            end
            default: begin
                rd_state_d = RIDLE;
            end
        endcase
    end

    assign rlast = (rd_state_q == RDATA) && (rbeat_q == rlen_q);

    // ---------------- optional error checking ----------------
`ifdef LSU_AXI_RSP_ERR_CHK_EN
    logic      wr_err_q, rd_err_q;
    axi_resp_e bresp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
            bresp_q  <= AXI_OKAY;
        end else begin
            if (awrdy && axi.lsu_axi_awvld) begin
                wr_err_q <= (axi.lsu_axi_awsize != AXI_SIZE_8B) || axi.lsu_axi_awburst[1];
            end
            if (arrdy && axi.lsu_axi_arvld) begin
                rd_err_q <= (axi.lsu_axi_arsize != AXI_SIZE_8B) || axi.lsu_axi_arburst[1];
            end
            // wbeat_q counts the beats before the wlast beat, so a correct
            // burst has exactly len of them.
            if (wrdy && axi.lsu_axi_wvld && axi.lsu_axi_wlast) begin
                bresp_q <= (wr_err_q || (wbeat_q != {1'b0, wlen_q})) ? AXI_SLVERR : AXI_OKAY;
            end else if (bvld && axi.lsu_axi_brdy) begin
                bresp_q <= AXI_OKAY;
            end
        end
    end

    assign wr_err = wr_err_q;
    assign rd_err = rd_err_q;
    assign bresp  = bresp_q;
    assign rresp  = (rd_state_q == RDATA && rd_err_q) ? AXI_SLVERR : AXI_OKAY;

    logic unused_ok;
    assign unused_ok = ^{axi.lsu_axi_awid[7:1], wstep[STEP_W-1:ADDR_W], rstep[STEP_W-1:ADDR_W]};
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
    assign bresp  = AXI_OKAY;
    assign rresp  = AXI_OKAY;

    logic unused_ok;
    assign unused_ok = ^{axi.lsu_axi_awid[7:1], axi.lsu_axi_awsize, axi.lsu_axi_arsize,
                         wstep[STEP_W-1:ADDR_W], rstep[STEP_W-1:ADDR_W]};
`endif

    // ---------------- memory ----------------
    lsu_axi_rsp_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (waddr_q),
        .wdata_i (axi.lsu_axi_wdata),
        .wstrb_i (axi.lsu_axi_wstrb),
        .re_i    (mem_re),
        .raddr_i (raddr_q),
        .rdata_o (mem_rdata)
    );

    // ---------------- outputs ----------------
    assign axi.axi_lsu_awrdy          = awrdy;
    assign axi.axi_lsu_wrdy           = wrdy;
    assign axi.axi_lsu_bvld           = bvld;
    assign axi.axi_lsu_bid            = bid_q;
    assign axi.axi_lsu_bresp          = bresp;
    assign axi.axi_lsu_resp_oram_addr = oram_q;
    assign axi.axi_lsu_arrdy          = arrdy;
    assign axi.axi_lsu_rvld           = rvld;
    assign axi.axi_lsu_rid            = rid_q;
    assign axi.axi_lsu_rlast          = rlast;
    assign axi.axi_lsu_rresp          = rresp;
    // Gated so rdata is zero outside a valid beat and on erroneous reads.
    assign axi.axi_lsu_rdata          = (rd_state_q == RDATA && !rd_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_lsu_axi_rsp.sv
// ---------------------------------------------------------------------------
// tb_lsu_axi_rsp
// Directed bench for lsu_axi_rsp. Inputs are driven and outputs sampled on
// the falling clock edge. Honours LSU_AXI_RSP_ERR_CHK_EN for the error cases.
// ---------------------------------------------------------------------------
module tb_lsu_axi_rsp;

`ifdef LSU_AXI_RSP_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_axi_rsp_if #(.DATA_W(64), .ADDR_W(10)) bus ();

    lsu_axi_rsp #(.DATA_W(64), .ADDR_W(10), .MEM_DEPTH(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .axi   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] ex [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wr_burst(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [2:0] str,
                            input logic [11:0] oram, input int nb, input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        bus.lsu_axi_awid      = id;
        bus.lsu_axi_awaddr    = addr;
        bus.lsu_axi_awlen     = len;
        bus.lsu_axi_awburst   = burst;
        bus.lsu_axi_awsize    = size;
        bus.lsu_axi_awstr     = str;
        bus.lsu_axi_oram_addr = oram;
        bus.lsu_axi_awvld     = 1'b1;
        n = 0;
        while (!bus.axi_lsu_awrdy && n < 50) begin @(negedge clk); n++; end
        chk("aw_hs", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.lsu_axi_awvld = 1'b0;
        for (int b = 0; b < nb; b++) begin
            bus.lsu_axi_wdata = wd[b];
            bus.lsu_axi_wstrb = ws[b];
            bus.lsu_axi_wlast = (b == nb - 1);
            bus.lsu_axi_wvld  = 1'b1;
            n = 0;
            while (!bus.axi_lsu_wrdy && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("w_hs", 64'd0, 64'd1);
            @(negedge clk);
        end
        bus.lsu_axi_wvld  = 1'b0;
        bus.lsu_axi_wlast = 1'b0;
        n = 0;
        while (!bus.axi_lsu_bvld && n < 50) begin @(negedge clk); n++; end
        chk("b_vld", 64'(bus.axi_lsu_bvld), 64'd1);
        chk("b_resp", 64'(bus.axi_lsu_bresp), 64'(exp_resp));
        chk("b_id", 64'(bus.axi_lsu_bid), 64'(id[0]));
        chk("b_oram", 64'(bus.axi_lsu_resp_oram_addr), 64'(oram));
        @(negedge clk);
        // brdy still low: the response must hold
        chk("b_hold", 64'(bus.axi_lsu_bvld), 64'd1);
        chk("b_hold_oram", 64'(bus.axi_lsu_resp_oram_addr), 64'(oram));
        bus.lsu_axi_brdy = 1'b1;
        @(negedge clk);
        bus.lsu_axi_brdy = 1'b0;
        chk("b_drop", 64'(bus.axi_lsu_bvld), 64'd0);
        $display("wr id=%h addr=%h len=%0d beats=%0d burst=%0d size=%0d", id, addr, len, nb, burst, size);
    endtask

    task automatic rd_burst(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input logic [2:0] str,
                            input bit stall, input logic [1:0] exp_resp);
        int n;
        int b;
        int cyc;
        logic rr;
        @(negedge clk);
        bus.lsu_axi_arid    = id;
        bus.lsu_axi_araddr  = addr;
        bus.lsu_axi_arlen   = len;
        bus.lsu_axi_arburst = burst;
        bus.lsu_axi_arsize  = size;
        bus.lsu_axi_arstr   = str;
        bus.lsu_axi_arvld   = 1'b1;
        n = 0;
        while (!bus.axi_lsu_arrdy && n < 50) begin @(negedge clk); n++; end
        chk("ar_hs", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.lsu_axi_arvld = 1'b0;
        b   = 0;
        cyc = 0;
        while (b <= int'(len) && cyc < 200) begin
            // A period-3 ready pattern never phase-locks with the 2-cycle
            // beat rate, so beats are repeatedly held across stalls.
            rr = stall ? ((cyc % 3) == 2) : 1'b1;
            bus.lsu_axi_rrdy = rr;
            if (bus.axi_lsu_rvld) begin
                chk("r_data", bus.axi_lsu_rdata, ex[b]);
                chk("r_last", 64'(bus.axi_lsu_rlast), 64'(b == int'(len)));
                chk("r_id", 64'(bus.axi_lsu_rid), 64'(id));
                chk("r_resp", 64'(bus.axi_lsu_rresp), 64'(exp_resp));
                if (rr) b++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.lsu_axi_rrdy = 1'b0;
        chk("r_beats", 64'(b), 64'(int'(len) + 1));
        $display("rd id=%h addr=%h len=%0d beats=%0d burst=%0d stall=%0d", id, addr, len, b, burst, stall);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.lsu_axi_awid = '0; bus.lsu_axi_awaddr = '0; bus.lsu_axi_awlen = '0;
        bus.lsu_axi_awsize = '0; bus.lsu_axi_awburst = '0; bus.lsu_axi_awstr = '0;
        bus.lsu_axi_awvld = 1'b0; bus.lsu_axi_oram_addr = '0;
        bus.lsu_axi_wdata = '0; bus.lsu_axi_wstrb = '0; bus.lsu_axi_wlast = 1'b0;
        bus.lsu_axi_wvld = 1'b0; bus.lsu_axi_brdy = 1'b0;
        bus.lsu_axi_arid = '0; bus.lsu_axi_araddr = '0; bus.lsu_axi_arlen = '0;
        bus.lsu_axi_arsize = '0; bus.lsu_axi_arburst = '0; bus.lsu_axi_arstr = '0;
        bus.lsu_axi_arvld = 1'b0; bus.lsu_axi_rrdy = 1'b0;
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 8'hFF; ex[i] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awrdy", 64'(bus.axi_lsu_awrdy), 64'd0);
        chk("rst_arrdy", 64'(bus.axi_lsu_arrdy), 64'd0);
        chk("rst_bvld", 64'(bus.axi_lsu_bvld), 64'd0);
        chk("rst_rvld", 64'(bus.axi_lsu_rvld), 64'd0);
        chk("rst_rdata", bus.axi_lsu_rdata, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_awrdy", 64'(bus.axi_lsu_awrdy), 64'd1);
        chk("post_rst_arrdy", 64'(bus.axi_lsu_arrdy), 64'd1);
        $display("reset released");

        // 1: 4-beat INCR write then readback
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; ex[i] = 64'hA0 + 64'(i); end
        wr_burst(8'h35, 10'h010, 8'd3, 2'b01, 3'd3, 3'd0, 12'hABC, 4, 2'b00);
        rd_burst(8'h5A, 10'h010, 8'd3, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);

        // 2: partial strobe overwrite
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        wr_burst(8'h02, 10'h020, 8'd0, 2'b01, 3'd3, 3'd0, 12'h123, 1, 2'b00);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        wr_burst(8'h03, 10'h020, 8'd0, 2'b01, 3'd3, 3'd0, 12'h456, 1, 2'b00);
        ex[0] = 64'hFFFF_FFFF_0000_0000;
        rd_burst(8'h21, 10'h020, 8'd0, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);

        // 3: strided INCR wrapping past the top of memory
        wd[0] = 64'h1111; wd[1] = 64'h2222; ws[0] = 8'hFF; ws[1] = 8'hFF;
        wr_burst(8'h04, 10'h3FC, 8'd1, 2'b01, 3'd3, 3'd2, 12'h3FC, 2, 2'b00);
        ex[0] = 64'h1111;
        rd_burst(8'h31, 10'h3FC, 8'd0, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);
        ex[0] = 64'h2222;
        rd_burst(8'h32, 10'h000, 8'd0, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);

        // FIXED burst: both beats hit the same word, last one wins
        wd[0] = 64'hC1; wd[1] = 64'hC2;
        wr_burst(8'h05, 10'h050, 8'd1, 2'b00, 3'd3, 3'd0, 12'h050, 2, 2'b00);
        ex[0] = 64'hC2;
        rd_burst(8'h33, 10'h050, 8'd0, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);

        // 4: 8-beat read with a stalling ready
        for (int i = 0; i < 8; i++) begin wd[i] = 64'hB0 + 64'(i); ws[i] = 8'hFF; ex[i] = 64'hB0 + 64'(i); end
        wr_burst(8'h06, 10'h100, 8'd7, 2'b01, 3'd3, 3'd0, 12'h100, 8, 2'b00);
        rd_burst(8'hC3, 10'h100, 8'd7, 2'b01, 3'd3, 3'd0, 1'b1, 2'b00);

        // Extra beat beyond len+1 is consumed but not written
        wd[0] = 64'h0; wd[1] = 64'h5;
        wr_burst(8'h07, 10'h060, 8'd1, 2'b01, 3'd3, 3'd0, 12'h060, 2, 2'b00);
        wd[0] = 64'hD1; wd[1] = 64'hEE;
        wr_burst(8'h08, 10'h060, 8'd0, 2'b01, 3'd3, 3'd0, 12'h061, 2, ERR_EN ? 2'b10 : 2'b00);
        ex[0] = 64'hD1; ex[1] = 64'h5;
        rd_burst(8'h34, 10'h060, 8'd1, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);

`ifdef LSU_AXI_RSP_ERR_CHK_EN
        // 5: illegal size on write, illegal burst on read
        wd[0] = 64'h0; ws[0] = 8'hFF;
        wr_burst(8'h09, 10'h020, 8'd0, 2'b01, 3'd2, 3'd0, 12'h777, 1, 2'b10);
        ex[0] = 64'hFFFF_FFFF_0000_0000;
        rd_burst(8'h35, 10'h020, 8'd0, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);
        ex[0] = 64'h0; ex[1] = 64'h0;
        rd_burst(8'h36, 10'h010, 8'd1, 2'b10, 3'd3, 3'd0, 1'b0, 2'b10);
`else
        // Without checking, burst 10 behaves as INCR
        ex[0] = 64'hA0; ex[1] = 64'hA1;
        rd_burst(8'h36, 10'h010, 8'd1, 2'b10, 3'd3, 3'd0, 1'b0, 2'b00);
`endif

        // 6: reset during beat 2 of a 4-beat write
        for (int i = 0; i < 4; i++) begin wd[i] = 64'h0; ws[i] = 8'hFF; end
        wr_burst(8'h0A, 10'h040, 8'd3, 2'b01, 3'd3, 3'd0, 12'h040, 4, 2'b00);
        @(negedge clk);
        bus.lsu_axi_awid = 8'h0B; bus.lsu_axi_awaddr = 10'h040; bus.lsu_axi_awlen = 8'd3;
        bus.lsu_axi_awburst = 2'b01; bus.lsu_axi_awsize = 3'd3; bus.lsu_axi_awstr = 3'd0;
        bus.lsu_axi_oram_addr = 12'h0B0; bus.lsu_axi_awvld = 1'b1;
        begin
            int n;
            n = 0;
            while (!bus.axi_lsu_awrdy && n < 50) begin @(negedge clk); n++; end
            chk("rst6_aw_hs", 64'(n < 50), 64'd1);
            @(negedge clk);
            bus.lsu_axi_awvld = 1'b0;
            for (int b = 0; b < 2; b++) begin
                bus.lsu_axi_wdata = 64'h6000 + 64'(b); bus.lsu_axi_wstrb = 8'hFF;
                bus.lsu_axi_wlast = 1'b0; bus.lsu_axi_wvld = 1'b1;
                n = 0;
                while (!bus.axi_lsu_wrdy && n < 50) begin @(negedge clk); n++; end
                if (n >= 50) chk("rst6_w_hs", 64'd0, 64'd1);
                @(negedge clk);
            end
        end
        bus.lsu_axi_wdata = 64'h6002; bus.lsu_axi_wvld = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.lsu_axi_wvld = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst6_awrdy", 64'(bus.axi_lsu_awrdy), 64'd1);
        chk("rst6_bvld", 64'(bus.axi_lsu_bvld), 64'd0);
        chk("rst6_wrdy", 64'(bus.axi_lsu_wrdy), 64'd0);
        $display("reset pulsed mid-burst");
        ex[0] = 64'h6000; ex[1] = 64'h6001; ex[2] = 64'h0; ex[3] = 64'h0;
        rd_burst(8'h37, 10'h040, 8'd3, 2'b01, 3'd3, 3'd0, 1'b0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
